// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, MIPS opcode/funct constants and the R-type funct decode.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_MUL  = 4'd8,
    ALU_DIV  = 4'd9,
    ALU_MFHI = 4'd10,
    ALU_MFLO = 4'd11
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_MUL  = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;

  // Unknown funct codes fall back to ADD so the datapath always has a defined op.
  function automatic alu_op_e rtype_op(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_XOR:  return ALU_XOR;
      FN_NOR:  return ALU_NOR;
      FN_SLT:  return ALU_SLT;
      FN_SLTU: return ALU_SLTU;
      FN_MUL:  return ALU_MUL;
      FN_DIV:  return ALU_DIV;
      FN_MFHI: return ALU_MFHI;
      FN_MFLO: return ALU_MFLO;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational opcode/funct to ALU operation decoder.
module alu_decoder
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_op_e    alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE:              alu_op = rtype_op(funct);
      OP_ADDI, OP_LW, OP_SW: alu_op = ALU_ADD;
      OP_BEQ, OP_BNE:        alu_op = ALU_SUB;
      OP_SLTI:               alu_op = ALU_SLT;
      OP_ANDI:               alu_op = ALU_AND;
      OP_ORI:                alu_op = ALU_OR;
      OP_XORI:               alu_op = ALU_XOR;
      default:               alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_top.sv
// 32-bit MIPS-style ALU: combinational datapath plus HI/LO registers loaded by DIV.
module alu_top
  import alu_pkg::*;
(
  input  logic        clkACC,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [3:0]  ALUop,
  output logic [31:0] ALUresult,
  output logic        zero,
  output logic        overflow
);

  alu_op_e     alu_op;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] product;
  logic        div_ovf;
  logic [31:0] div_b;
  logic [31:0] quotient;
  logic [31:0] remainder;

  alu_decoder u_decoder (
    .opcode (opcode),
    .funct  (funct),
    .alu_op (alu_op)
  );

  assign ALUop   = alu_op;
  assign sum     = A + B;
  assign diff    = A - B;
  assign product = $signed(A) * $signed(B);

  // Divisor is forced to 1 for B==0 and for -2^31/-1 so the divider never sees an undefined case.
  assign div_ovf   = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign div_b     = ((B == 32'h0) || div_ovf) ? 32'h1 : B;
  assign quotient  = div_ovf ? 32'h8000_0000 : 32'($signed(A) / $signed(div_b));
  assign remainder = div_ovf ? 32'h0 : 32'($signed(A) % $signed(div_b));

  always_comb begin
    ALUresult = 32'h0;
    overflow  = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        ALUresult = sum;
        overflow  = (A[31] == B[31]) && (sum[31] != A[31]);
      end
      ALU_SUB: begin
        ALUresult = diff;
        overflow  = (A[31] != B[31]) && (diff[31] != A[31]);
      end
      ALU_AND:  ALUresult = A & B;
      ALU_OR:   ALUresult = A | B;
      ALU_XOR:  ALUresult = A ^ B;
      ALU_NOR:  ALUresult = ~(A | B);
      ALU_SLT:  ALUresult = {31'b0, $signed(A) < $signed(B)};
      ALU_SLTU: ALUresult = {31'b0, A < B};
      ALU_MUL:  ALUresult = product;
      ALU_DIV:  ALUresult = 32'h0;
      ALU_MFHI: ALUresult = hi_reg;
      ALU_MFLO: ALUresult = lo_reg;
      default:  ALUresult = 32'h0;
    endcase
  end

  assign zero = (ALUresult == 32'h0);

  always_ff @(posedge clkACC or posedge rst) begin
    if (rst) begin
      hi_reg <= 32'h0;
      lo_reg <= 32'h0;
    end else if ((alu_op == ALU_DIV) && (B != 32'h0)) begin
      hi_reg <= remainder;
      lo_reg <= quotient;
    end
  end

endmodule

// File: tb/tb_alu_top.sv
// Self-checking bench for alu_top: directed vector table, HI/LO sequences and a signed reference loop.
module tb_alu_top;
  import alu_pkg::*;

  logic        clkACC;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUop;
  logic [31:0] ALUresult;
  logic        zero;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  alu_top dut (
    .clkACC    (clkACC),
    .rst       (rst),
    .opcode    (opcode),
    .funct     (funct),
    .A         (A),
    .B         (B),
    .ALUop     (ALUop),
    .ALUresult (ALUresult),
    .zero      (zero),
    .overflow  (overflow)
  );

  initial clkACC = 1'b0;
  always #5 clkACC = ~clkACC;

  typedef struct {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  exp_op;
    logic [31:0] exp_res;
    logic        exp_ov;
    logic        exp_zero;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 4 units later.
  task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    @(posedge clkACC);
    #1;
    opcode = op;
    funct  = fn;
    A      = a;
    B      = b;
    #4;
  endtask

  logic [31:0] ra, rb, e_add, e_sub, e_mul, e_slt, e_q, e_r;
  logic        e_add_ov, e_sub_ov;
  longint      sa, sb, s_add, s_sub;

  initial begin
    vecs[0]  = '{OP_RTYPE, FN_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 4'd0, 32'h8000_0000, 1'b1, 1'b0};
    vecs[1]  = '{OP_RTYPE, FN_SUB,  32'h0000_0005, 32'h0000_0005, 4'd1, 32'h0000_0000, 1'b0, 1'b1};
    vecs[2]  = '{OP_RTYPE, FN_SUB,  32'h8000_0000, 32'h0000_0001, 4'd1, 32'h7FFF_FFFF, 1'b1, 1'b0};
    vecs[3]  = '{OP_RTYPE, FN_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd2, 32'h00F0_00F0, 1'b0, 1'b0};
    vecs[4]  = '{OP_RTYPE, FN_OR,   32'h1234_0000, 32'h0000_5678, 4'd3, 32'h1234_5678, 1'b0, 1'b0};
    vecs[5]  = '{OP_RTYPE, FN_XOR,  32'hFFFF_0000, 32'hFF00_FF00, 4'd4, 32'h00FF_FF00, 1'b0, 1'b0};
    vecs[6]  = '{OP_RTYPE, FN_NOR,  32'h0000_0000, 32'h0000_0000, 4'd5, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[7]  = '{OP_RTYPE, FN_SLT,  32'h8000_0000, 32'h0000_0001, 4'd6, 32'h0000_0001, 1'b0, 1'b0};
    vecs[8]  = '{OP_RTYPE, FN_SLTU, 32'h8000_0000, 32'h0000_0001, 4'd7, 32'h0000_0000, 1'b0, 1'b1};
    vecs[9]  = '{OP_RTYPE, FN_MUL,  32'hFFFF_FFFE, 32'h0000_0003, 4'd8, 32'hFFFF_FFFA, 1'b0, 1'b0};
    vecs[10] = '{OP_ADDI,  6'd0,    32'h0000_0003, 32'h0000_0004, 4'd0, 32'h0000_0007, 1'b0, 1'b0};
    vecs[11] = '{OP_LW,    6'd0,    32'h0000_000A, 32'h0000_0014, 4'd0, 32'h0000_001E, 1'b0, 1'b0};
    vecs[12] = '{OP_BEQ,   6'd0,    32'h0000_0009, 32'h0000_0009, 4'd1, 32'h0000_0000, 1'b0, 1'b1};
    vecs[13] = '{OP_BNE,   6'd0,    32'h0000_0009, 32'h0000_0003, 4'd1, 32'h0000_0006, 1'b0, 1'b0};
    vecs[14] = '{OP_SLTI,  6'd0,    32'hFFFF_FFFF, 32'h0000_0000, 4'd6, 32'h0000_0001, 1'b0, 1'b0};
    vecs[15] = '{OP_ANDI,  6'd0,    32'h0000_00FF, 32'h0000_000F, 4'd2, 32'h0000_000F, 1'b0, 1'b0};
    vecs[16] = '{OP_ORI,   6'd0,    32'h0000_00F0, 32'h0000_000F, 4'd3, 32'h0000_00FF, 1'b0, 1'b0};
    vecs[17] = '{OP_XORI,  6'd0,    32'h0000_00FF, 32'h0000_000F, 4'd4, 32'h0000_00F0, 1'b0, 1'b0};
    vecs[18] = '{6'b111111, 6'd0,   32'h0000_0002, 32'h0000_0003, 4'd0, 32'h0000_0005, 1'b0, 1'b0};
    vecs[19] = '{OP_RTYPE, 6'b000001, 32'h0000_0002, 32'h0000_0003, 4'd0, 32'h0000_0005, 1'b0, 1'b0};
    vecs[20] = '{OP_RTYPE, FN_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 4'd0, 32'h0000_0000, 1'b0, 1'b1};
    vecs[21] = '{OP_RTYPE, FN_ADD,  32'h8000_0000, 32'h8000_0000, 4'd0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[22] = '{OP_SW,    6'd0,    32'h0000_0004, 32'h0000_0004, 4'd0, 32'h0000_0008, 1'b0, 1'b0};

    // Reset state: HI/LO read back as zero.
    rst = 1'b0;
    opcode = OP_RTYPE;
    funct  = FN_MFHI;
    A = 32'h0;
    B = 32'h0;
    #1 rst = 1'b1;
    #2;
    check("reset_mfhi", ALUresult, 32'h0);
    check("reset_mfhi_zero", {31'b0, zero}, 32'h1);
    check("reset_mfhi_op", {28'b0, ALUop}, 32'd10);
    funct = FN_MFLO;
    #1;
    check("reset_mflo", ALUresult, 32'h0);
    @(negedge clkACC);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      apply(vecs[i].opcode, vecs[i].funct, vecs[i].a, vecs[i].b);
      $display("vec %0d op=%0d A=%h B=%h res=%h ov=%0b z=%0b", i, ALUop, A, B, ALUresult, overflow, zero);
      check($sformatf("vec%0d_op", i),   {28'b0, ALUop},     {28'b0, vecs[i].exp_op});
      check($sformatf("vec%0d_res", i),  ALUresult,          vecs[i].exp_res);
      check($sformatf("vec%0d_ov", i),   {31'b0, overflow},  {31'b0, vecs[i].exp_ov});
      check($sformatf("vec%0d_zero", i), {31'b0, zero},      {31'b0, vecs[i].exp_zero});
    end

    // DIV -7 / 2: quotient -3, remainder -1.
    apply(OP_RTYPE, FN_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    $display("div -7/2 res=%h", ALUresult);
    check("div_cycle_res", ALUresult, 32'h0);
    check("div_cycle_zero", {31'b0, zero}, 32'h1);
    check("div_cycle_op", {28'b0, ALUop}, 32'd9);
    apply(OP_RTYPE, FN_MFHI, 32'h0, 32'h0);
    $display("mfhi res=%h", ALUresult);
    check("div_mfhi", ALUresult, 32'hFFFF_FFFF);
    funct = FN_MFLO;
    #1;
    $display("mflo res=%h", ALUresult);
    check("div_mflo", ALUresult, 32'hFFFF_FFFD);

    // Asynchronous reset between edges clears HI/LO immediately.
    rst = 1'b1;
    #1;
    check("rst_async_mflo", ALUresult, 32'h0);
    funct = FN_MFHI;
    #1;
    check("rst_async_mfhi", ALUresult, 32'h0);
    $display("async reset mfhi=%h", ALUresult);
    @(negedge clkACC);
    rst = 1'b0;

    // Load 100/7 then DIV by zero must leave HI=2, LO=14.
    apply(OP_RTYPE, FN_DIV, 32'd100, 32'd7);
    apply(OP_RTYPE, FN_DIV, 32'd55, 32'd0);
    check("div0_cycle_res", ALUresult, 32'h0);
    apply(OP_RTYPE, FN_MFHI, 32'h0, 32'h0);
    check("div0_hi_kept", ALUresult, 32'd2);
    funct = FN_MFLO;
    #1;
    check("div0_lo_kept", ALUresult, 32'd14);
    $display("div by zero hold lo=%h", ALUresult);

    // Most-negative / -1 wraps the quotient.
    apply(OP_RTYPE, FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    apply(OP_RTYPE, FN_MFLO, 32'h0, 32'h0);
    check("divovf_lo", ALUresult, 32'h8000_0000);
    funct = FN_MFHI;
    #1;
    check("divovf_hi", ALUresult, 32'h0);
    $display("div ovf hi=%h", ALUresult);

    // Reset held across a DIV edge wins over the load.
    apply(OP_RTYPE, FN_DIV, 32'd100, 32'd7);
    rst = 1'b1;
    @(posedge clkACC);
    #1;
    funct = FN_MFLO;
    #1;
    check("rst_priority_lo", ALUresult, 32'h0);
    @(negedge clkACC);
    rst = 1'b0;

    // Signed reference model over negative operands.
    for (int it = 0; it < 100; it++) begin
      ra = 32'h8000_0000 | $urandom;
      rb = 32'hFFFF_8000 | {17'b0, 15'($urandom_range(0, 32767))};
      sa = longint'($signed(ra));
      sb = longint'($signed(rb));
      s_add = sa + sb;
      s_sub = sa - sb;
      e_add = s_add[31:0];
      e_sub = s_sub[31:0];
      e_add_ov = (s_add > 64'sd2147483647) || (s_add < -64'sd2147483648);
      e_sub_ov = (s_sub > 64'sd2147483647) || (s_sub < -64'sd2147483648);
      begin
        longint p, q, r;
        p = sa * sb;
        q = sa / sb;
        r = sa % sb;
        e_mul = p[31:0];
        e_q   = q[31:0];
        e_r   = r[31:0];
      end
      e_slt = (sa < sb) ? 32'd1 : 32'd0;

      apply(OP_RTYPE, FN_ADD, ra, rb);
      check($sformatf("rnd%0d_add", it), ALUresult, e_add);
      check($sformatf("rnd%0d_add_ov", it), {31'b0, overflow}, {31'b0, e_add_ov});
      apply(OP_RTYPE, FN_SUB, ra, rb);
      check($sformatf("rnd%0d_sub", it), ALUresult, e_sub);
      check($sformatf("rnd%0d_sub_ov", it), {31'b0, overflow}, {31'b0, e_sub_ov});
      apply(OP_RTYPE, FN_MUL, ra, rb);
      check($sformatf("rnd%0d_mul", it), ALUresult, e_mul);
      apply(OP_RTYPE, FN_SLT, ra, rb);
      check($sformatf("rnd%0d_slt", it), ALUresult, e_slt);
      apply(OP_RTYPE, FN_DIV, ra, rb);
      apply(OP_RTYPE, FN_MFHI, 32'h0, 32'h0);
      check($sformatf("rnd%0d_hi", it), ALUresult, e_r);
      funct = FN_MFLO;
      #1;
      check($sformatf("rnd%0d_lo", it), ALUresult, e_q);
      $display("rnd %0d A=%h B=%h q=%h r=%h", it, ra, rb, e_q, e_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_top.md
ALU_TOP -- requirements
Module: alu_top

Interface
REQ-001 SHALL have ports: clkACC  input  1  single clock, rising-edge active; HI/LO update only.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: opcode  input  6  instruction opcode; funct  input  6  R-type function field.
REQ-004 SHALL have ports: A  input  32  operand A; B  input  32  operand B (both two's complement where signed).
REQ-005 SHALL have ports: ALUop  output  4  decoded operation; ALUresult  output  32  result.
REQ-006 SHALL have ports: zero  output  1  ALUresult==0; overflow  output  1  signed overflow flag.

Function
REQ-007 SHALL decode opcode/funct to ALUop combinationally, encoding 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 MUL, 9 DIV, 10 MFHI, 11 MFLO; 12-15 unused.
REQ-008 SHALL, for opcode 000000 (RTYPE1), map funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 101011 SLTU, 011000 MUL, 011010 DIV, 010000 MFHI, 010010 MFLO.
REQ-009 SHALL map opcodes 001000 ADDI, 100011 LW, 101011 SW to ADD; 000100 BEQ, 000101 BNE to SUB; 001010 to SLT; 001100 to AND; 001101 to OR; 001110 to XOR.
REQ-010 SHALL decode any unlisted opcode/funct as ADD.
REQ-011 SHALL compute ALUresult combinationally from A, B, ALUop; it SHALL settle within the same cycle and never be X.
REQ-012 ADD/SUB SHALL be 32-bit modulo; overflow=1 iff the signed result does not fit in 32 bits, else 0.
REQ-013 overflow SHALL be 0 for all ops other than ADD/SUB.
REQ-014 SLT SHALL return 1 if $signed(A)<$signed(B), else 0; SLTU SHALL compare unsigned; upper 31 bits 0.
REQ-015 MUL SHALL return the low 32 bits of the signed product A*B.
REQ-016 DIV SHALL drive ALUresult=0 and SHALL compute signed quotient (truncate toward zero) and remainder (sign of A).
REQ-017 On a rising clkACC edge with ALUop=DIV and B!=0, SHALL load LO<=quotient and HI<=remainder.
REQ-018 SHALL leave HI/LO unchanged for DIV with B==0.
REQ-019 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, load LO=0x80000000 and HI=0.
REQ-020 MFHI SHALL output HI and MFLO SHALL output LO (register values, zero added latency).
REQ-021 zero SHALL equal (ALUresult==32'h0) for every op.

Reset
REQ-022 rst high SHALL asynchronously clear HI and LO to 0; rst has priority over a simultaneous DIV edge.
REQ-023 Combinational outputs SHALL be unaffected by rst except through HI/LO (MFHI/MFLO read 0 during/after reset).

Structure
REQ-024 ALUop encodings, opcode and funct constants SHALL live in a shared package/header used by decoder, ALU and bench.
REQ-025 SHALL instantiate one sub-module alu_decoder (opcode, funct -> ALUop); the datapath and HI/LO SHALL be in alu_top.

Verification
REQ-026 ADD A=0x7FFFFFFF, B=0x00000001 -> ALUresult=0x80000000, overflow=1, zero=0.
REQ-027 SUB A=0x00000005, B=0x00000005 -> ALUresult=0, zero=1, overflow=0.
REQ-028 DIV A=0xFFFFFFF9 (-7), B=0x00000002, one clkACC edge, then MFHI -> 0xFFFFFFFF and MFLO -> 0xFFFFFFFD; DIV cycle result 0.
REQ-029 MUL A=0xFFFFFFFE, B=0x00000003 -> 0xFFFFFFFA; SLT A=0x80000000, B=0x00000001 -> 1; SLTU same operands -> 0.
REQ-030 After REQ-028, assert rst between edges -> MFHI and MFLO immediately 0; DIV with B=0 then edge -> HI/LO unchanged.
REQ-031 Randomized loop (100 iterations, A MSB=1, B=0xFFFF8000|rand15) -> ADD, SUB, MUL, SLT, DIV-then-MFHI match the signed reference model.
